apb_slave_mem: RTL and testbench

APB_SLAVE_MEM -- requirements
Module: apb_slave_mem

---
 rtl/apb_slave_mem.sv | 120 ++++++++++++
 tb/tb_apb_slave_mem.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_slave_mem.sv
// APB slave backed by a word-addressed register-file memory.
// Configurable wait states; misaligned or out-of-range accesses complete with PSLVERR.
// PREADY, PSLVERR and PRDATA are all registered.
module apb_slave_mem #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  PSELx,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR
);

    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  write_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [3:0]            cnt_q;
    logic [DATA_WIDTH-1:0] prdata_q;
    logic                  pready_q;
    logic                  pslverr_q;
    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    logic [ADDR_WIDTH-1:0] dec_addr;
    logic                  dec_write;
    logic [IDX_W-1:0]      dec_idx;
    logic                  dec_err_d;
    logic [DATA_WIDTH-1:0] rdata_d;

    // Decode the transfer being answered: the live bus at setup (needed when there
    // are no wait states), the captured copy once in ACCESS.
    always_comb begin
        dec_addr  = (state_q == IDLE) ? PADDR : addr_q;
        dec_write = (state_q == IDLE) ? PWRITE : write_q;
        dec_idx   = dec_addr[IDX_W+1:2];
        dec_err_d = (dec_addr[1:0] != 2'b00) ||
                    ((dec_addr >> 2) >= ADDR_WIDTH'(MEM_DEPTH));
        rdata_d   = (!dec_write && !dec_err_d) ? mem_q[dec_idx] : '0;
    end

    // Transfer FSM with registered response outputs and memory write port.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            cnt_q     <= '0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            for (int unsigned i = 0; i < MEM_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (PSELx && !PENABLE) begin
                        addr_q  <= PADDR;
                        write_q <= PWRITE;
                        wdata_q <= PWDATA;
                        cnt_q   <= 4'(WAIT_STATES);
                        state_q <= ACCESS;
                        if (WAIT_STATES == 0) begin
                            pready_q  <= 1'b1;
                            prdata_q  <= rdata_d;
                            pslverr_q <= dec_err_d;
                        end else begin
                            pready_q  <= 1'b0;
                        end
                    end
                end
                ACCESS: begin
                    if (!PSELx) begin
                        state_q   <= IDLE;
                        cnt_q     <= '0;
                        pready_q  <= 1'b0;
                        pslverr_q <= 1'b0;
                    end else if (!pready_q) begin
                        cnt_q <= cnt_q - 4'd1;
                        if (cnt_q == 4'd1) begin
                            pready_q  <= 1'b1;
                            prdata_q  <= rdata_d;
                            pslverr_q <= dec_err_d;
                        end
                    end else if (PENABLE) begin
                        // pslverr_q already holds this transfer's error status here
                        if (write_q && !pslverr_q) begin
                            mem_q[dec_idx] <= wdata_q;
                        end
                        state_q   <= IDLE;
                        pready_q  <= 1'b0;
                        pslverr_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign PRDATA  = prdata_q;
    assign PREADY  = pready_q;
    assign PSLVERR = pslverr_q;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Bench for apb_slave_mem: three instances (WAIT_STATES = 1, 0, 3) share one APB
// master. Expected responses come from an array model of the memory and are queued
// at issue time; a negedge monitor matches every completion against that queue.
module tb_apb_slave_mem;

    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic        PSELx;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] prdata  [3];
    logic        pready  [3];
    logic        pslverr [3];

    exp_t        exp_q [$];
    int          rd_ptr [3];
    int          acc    [3];
    bit          done   [3];
    logic [31:0] mem_m  [256];
    int          checks   = 0;
    int          failures = 0;

    always #5 PCLK = ~PCLK;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        apb_slave_mem #(
            .ADDR_WIDTH (32),
            .DATA_WIDTH (32),
            .MEM_DEPTH  (256),
            .WAIT_STATES((g == 0) ? 1 : ((g == 1) ? 0 : 3))
        ) u_dut (
            .PCLK   (PCLK),
            .PRESETn(PRESETn),
            .PSELx  (PSELx),
            .PENABLE(PENABLE),
            .PWRITE (PWRITE),
            .PADDR  (PADDR),
            .PWDATA (PWDATA),
            .PRDATA (prdata[g]),
            .PREADY (pready[g]),
            .PSLVERR(pslverr[g])
        );
    end

    function automatic int ws_of(int g);
        case (g)
            0:       return 1;
            1:       return 0;
            default: return 3;
        endcase
    endfunction

    function automatic bit is_err(logic [31:0] a);
        return (a[1:0] != 2'b00) || ((a >> 2) >= 32'd256);
    endfunction

    function automatic bit all_done();
        return done[0] && done[1] && done[2];
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    task automatic check_quiet(string tag, bit with_data);
        for (int g = 0; g < 3; g++) begin
            check($sformatf("%s_pready_i%0d", tag, g), 32'(pready[g]), 32'd0);
            check($sformatf("%s_pslverr_i%0d", tag, g), 32'(pslverr[g]), 32'd0);
            if (with_data) check($sformatf("%s_prdata_i%0d", tag, g), prdata[g], 32'd0);
        end
    endtask

    task automatic idle(int n);
        PSELx   = 1'b0;
        PENABLE = 1'b0;
        repeat (n) begin
            @(posedge PCLK);
            #1;
        end
    endtask

    // Full transfer; entered and left at posedge+1, so calls chain back-to-back.
    task automatic xfer(bit wr, logic [31:0] a, logic [31:0] d);
        exp_t     e;
        bit       ok;
        logic [7:0] idx;
        idx     = a[9:2];
        e.addr  = a;
        e.write = wr;
        e.err   = is_err(a);
        e.rdata = (wr || e.err) ? 32'd0 : mem_m[idx];
        if (wr && !e.err) mem_m[idx] = d;
        exp_q.push_back(e);
        PSELx   = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = wr;
        PADDR   = a;
        PWDATA  = d;
        @(posedge PCLK);
        #1;
        PENABLE = 1'b1;
        PADDR   = $urandom;
        PWDATA  = $urandom;
        PWRITE  = 1'($urandom_range(0, 1));
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge PCLK);
            #1;
            if (all_done()) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL timeout addr=0x%08h actual=no_completion required=completion", a);
            PSELx   = 1'b0;
            PENABLE = 1'b0;
        end
    endtask

    // Monitor: match each instance's completion against the scoreboard queue.
    initial begin
        exp_t e;
        done = '{1'b1, 1'b1, 1'b1};
        rd_ptr = '{0, 0, 0};
        acc = '{0, 0, 0};
        forever begin
            @(negedge PCLK);
            if (PRESETn && PSELx && !PENABLE) begin
                for (int g = 0; g < 3; g++) begin
                    acc[g]  = 0;
                    done[g] = 1'b0;
                end
            end else if (PRESETn && PSELx && PENABLE) begin
                for (int g = 0; g < 3; g++) begin
                    if (!done[g]) begin
                        acc[g]++;
                        if (pready[g]) begin
                            done[g] = 1'b1;
                            if (rd_ptr[g] >= exp_q.size()) begin
                                checks++;
                                failures++;
                                $display("FAIL unexpected_completion_i%0d actual=completion required=none", g);
                            end else begin
                                e = exp_q[rd_ptr[g]];
                                rd_ptr[g]++;
                                check($sformatf("prdata_i%0d@%08h", g, e.addr), prdata[g], e.rdata);
                                check($sformatf("pslverr_i%0d@%08h", g, e.addr), 32'(pslverr[g]), 32'(e.err));
                                check($sformatf("latency_i%0d@%08h", g, e.addr), 32'(acc[g]), 32'(ws_of(g) + 1));
                            end
                        end
                    end
                end
            end
        end
    end

    // Stimulus: directed scenarios, then randomized traffic.
    initial begin
        logic [31:0] a;
        int          kind;
        PRESETn = 1'b0;
        PSELx   = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        PADDR   = '0;
        PWDATA  = '0;
        for (int i = 0; i < 256; i++) mem_m[i] = '0;
        repeat (3) @(posedge PCLK);
        #1;
        check_quiet("reset", 1'b1);
        PRESETn = 1'b1;

        // Basic write/read, immediately after reset release
        xfer(1'b1, 32'h10, 32'hDEADBEEF);
        idle(1);
        xfer(1'b0, 32'h10, 32'h0);
        idle(1);

        // Error transfers leave memory untouched
        xfer(1'b0, 32'h400, 32'h0);
        idle(1);
        xfer(1'b1, 32'h13, 32'h12345678);
        idle(1);
        xfer(1'b0, 32'h10, 32'h0);
        idle(1);

        // Back-to-back writes and reads
        xfer(1'b1, 32'h0, 32'h11111111);
        xfer(1'b1, 32'h4, 32'h22222222);
        xfer(1'b0, 32'h0, 32'h0);
        xfer(1'b0, 32'h4, 32'h0);
        idle(1);

        // Access phase without setup is ignored
        PSELx   = 1'b1;
        PENABLE = 1'b1;
        PWRITE  = 1'b1;
        PADDR   = 32'h0;
        PWDATA  = 32'hBAD0BAD0;
        @(posedge PCLK);
        #1;
        check_quiet("stray", 1'b0);
        idle(1);
        xfer(1'b0, 32'h0, 32'h0);
        idle(1);

        // PSELx dropped right after setup aborts the write
        xfer(1'b1, 32'hC, 32'h0C0C0C0C);
        idle(1);
        PSELx   = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = 1'b1;
        PADDR   = 32'hC;
        PWDATA  = 32'h99999999;
        @(posedge PCLK);
        #1;
        PSELx = 1'b0;
        @(posedge PCLK);
        #1;
        check_quiet("abort", 1'b0);
        xfer(1'b0, 32'hC, 32'h0);
        idle(1);

        // Reset during ACCESS discards the write and clears memory
        PSELx   = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = 1'b1;
        PADDR   = 32'h8;
        PWDATA  = 32'hA5A5A5A5;
        @(posedge PCLK);
        #1;
        PENABLE = 1'b1;
        PRESETn = 1'b0;
        @(posedge PCLK);
        #1;
        PRESETn = 1'b1;
        PSELx   = 1'b0;
        PENABLE = 1'b0;
        check_quiet("midreset", 1'b1);
        for (int i = 0; i < 256; i++) mem_m[i] = '0;
        xfer(1'b0, 32'h8, 32'h0);
        xfer(1'b0, 32'h10, 32'h0);
        idle(1);

        // Randomized traffic
        repeat (60) begin
            kind = int'($urandom_range(0, 9));
            if (kind < 5)      a = 32'($urandom_range(0, 15)) << 2;
            else if (kind < 8) a = 32'($urandom_range(0, 255)) << 2;
            else if (kind == 8) a = (32'($urandom_range(0, 255)) << 2) | 32'($urandom_range(1, 3));
            else               a = 32'h400 + (32'($urandom_range(0, 1023)) << 2);
            xfer(1'($urandom_range(0, 1)), a, $urandom);
            if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 2)));
        end
        idle(2);

        for (int g = 0; g < 3; g++) begin
            check($sformatf("consumed_i%0d", g), 32'(rd_ptr[g]), 32'(exp_q.size()));
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
